// File: rtl/riscv_mem_pkg.sv
// Shared memory-access definitions for the core controller and the load/store
// byte bridge.
//   MEM_*          : size codes carried on MemWrite / ResultSrc
//   bridge_state_t : byte bridge state encoding
//   last_beat()    : index of the final byte beat for a size code
package riscv_mem_pkg;

   localparam logic [1:0] MEM_NONE = 2'b00;
   localparam logic [1:0] MEM_W    = 2'b01;
   localparam logic [1:0] MEM_H    = 2'b10;
   localparam logic [1:0] MEM_B    = 2'b11;

   typedef enum logic [1:0] {
      BR_IDLE = 2'd0,
      BR_BEAT = 2'd1,
      BR_DONE = 2'd2
   } bridge_state_t;

   function automatic logic [1:0] last_beat(input logic [1:0] size);
      logic [1:0] lb;
      case (size)
         MEM_W:   lb = 2'd3;
         MEM_H:   lb = 2'd1;
         default: lb = 2'd0;
      endcase
      return lb;
   endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load data extension: sign- or zero-extends assembled load bytes to 32 bits.
//   raw_data    in  32  assembled little-endian load bytes
//   size        in   2  MEM_W / MEM_H / MEM_B
//   is_unsigned in   1  1 = zero-extend, 0 = sign-extend
//   ext_data    out 32  extended result (word passes through)
module lsu_load_extend
   import riscv_mem_pkg::*;
(
   input  logic [31:0] raw_data,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] ext_data
);

   always_comb begin
      ext_data = raw_data;
      case (size)
         MEM_B:   ext_data = {{24{~is_unsigned & raw_data[7]}},  raw_data[7:0]};
         MEM_H:   ext_data = {{16{~is_unsigned & raw_data[15]}}, raw_data[15:0]};
         default: ext_data = raw_data;
      endcase
   end

endmodule

// File: rtl/lsu_byte_bridge.sv
// Load/store bridge: splits a core data access into 1/2/4 little-endian byte
// beats on an 8-bit req/ack bus, stalls the core meanwhile and returns the
// extended load data with a one-cycle done pulse. A per-beat timeout aborts a
// beat that is never acknowledged and flags err.
//   clk, reset (async, active-low)
//   core side : mem_req, MemWrite, ResultSrc, load_unsigned, addr, wdata
//               -> stall, done, rdata, err
//   bus side  : bus_req, bus_we, bus_addr, bus_wdata <- bus_ack, bus_rdata
//
// state   | meaning
// IDLE    | waiting for a core access
// BEAT    | bus_req high for byte beat beat_q, waiting for ack or timeout
// DONE    | done pulse, rdata/err presented, then back to IDLE
module lsu_byte_bridge
   import riscv_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_req,
   input  logic [1:0]  MemWrite,
   input  logic [1:0]  ResultSrc,
   input  logic        load_unsigned,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [7:0]  bus_wdata,
   input  logic        bus_ack,
   input  logic [7:0]  bus_rdata
);

   localparam int unsigned    TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0]  TMO_LOAD = TW'(TIMEOUT);
   localparam bit             TMO_EN   = (TIMEOUT != 0);

   bridge_state_t state_q, state_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   data_q, data_d;
   logic [1:0]    size_q, size_d;
   logic [1:0]    beat_q, beat_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          uns_q, uns_d;
   logic          we_q, we_d;
   logic          err_q, err_d;

   logic          op_present;
   logic          accept;
   logic [31:0]   ext_data;

   assign op_present = (MemWrite != MEM_NONE) | (ResultSrc != MEM_NONE);
   assign accept     = mem_req & op_present;

   lsu_load_extend u_extend (
      .raw_data    (data_q),
      .size        (size_q),
      .is_unsigned (uns_q),
      .ext_data    (ext_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= BR_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         data_q  <= '0;
         size_q  <= MEM_NONE;
         beat_q  <= '0;
         tmo_q   <= '0;
         uns_q   <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         size_q  <= size_d;
         beat_q  <= beat_d;
         tmo_q   <= tmo_d;
         uns_q   <= uns_d;
         we_q    <= we_d;
         err_q   <= err_d;
      end
   end

   // An ack on the same cycle the timer expires still completes the beat.
   always_comb begin
      state_d = state_q;
      case (state_q)
         BR_IDLE: if (accept) state_d = BR_BEAT;
         BR_BEAT: begin
            if (bus_ack) begin
               if (beat_q == last_beat(size_q)) state_d = BR_DONE;
            end else if (TMO_EN && tmo_q == '0) begin
               state_d = BR_DONE;
            end
         end
         BR_DONE: state_d = BR_IDLE;
         default: state_d = BR_IDLE;
      endcase
   end

   // The timer is a down-counter reloaded per beat; reaching zero with no
   // ack means TIMEOUT+1 request cycles have elapsed on this beat.
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      data_d  = data_q;
      size_d  = size_q;
      beat_d  = beat_q;
      tmo_d   = tmo_q;
      uns_d   = uns_q;
      we_d    = we_q;
      err_d   = err_q;
      case (state_q)
         BR_IDLE: begin
            if (accept) begin
               addr_d  = addr;
               wdata_d = wdata;
               uns_d   = load_unsigned;
               we_d    = (MemWrite != MEM_NONE);
               size_d  = (MemWrite != MEM_NONE) ? MemWrite : ResultSrc;
               beat_d  = '0;
               tmo_d   = TMO_LOAD;
               data_d  = '0;
               err_d   = 1'b0;
            end
         end
         BR_BEAT: begin
            if (bus_ack) begin
               if (!we_q) data_d[{beat_q, 3'b000} +: 8] = bus_rdata;
               beat_d = beat_q + 2'd1;
               tmo_d  = TMO_LOAD;
            end else if (TMO_EN) begin
               if (tmo_q == '0) err_d = 1'b1;
               else             tmo_d = tmo_q - 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      done      = (state_q == BR_DONE);
      err       = done & err_q;
      bus_req   = (state_q == BR_BEAT);
      bus_we    = bus_req & we_q;
      bus_addr  = bus_req ? (addr_q + {30'd0, beat_q}) : '0;
      bus_wdata = bus_we ? wdata_q[{beat_q, 3'b000} +: 8] : '0;
      rdata     = (done & ~we_q & ~err_q) ? ext_data : '0;
      stall     = accept & ~done;
   end

endmodule

// File: doc/lsu_byte_bridge.md
# lsu_byte_bridge

Load/store bridge between the single-cycle core's data-memory controls and an external 8-bit request/acknowledge memory bus. It takes the store size code on `MemWrite` and the load size code on `ResultSrc`, which the controller produces, and splits each access into 1, 2 or 4 little-endian byte beats. It stalls the core until the access completes, then returns the assembled, sign- or zero-extended load data with a one-cycle `done` pulse. A per-beat timeout aborts an access whose beat is never acknowledged and reports an error.

## Interface
- `TIMEOUT`, default 64: maximum cycles `bus_req` may wait for `bus_ack` on one beat; 0 disables the timeout.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low; all state and outputs clear while low.
- `mem_req`  input  1  core presents an access this cycle.
- `MemWrite`  input  2  store size: 00 none, 01 word, 10 half, 11 byte.
- `ResultSrc`  input  2  load size: 00 none, 01 word, 10 half, 11 byte.
- `load_unsigned`  input  1  1 selects zero-extension (LBU/LHU); 0 selects sign-extension.
- `addr`  input  32  byte address of beat 0.
- `wdata`  input  32  store data; beat i sends `wdata[8i+7:8i]`.
- `stall`  output  1  combinational: `mem_req & (MemWrite!=0 | ResultSrc!=0) & ~done`.
- `done`  output  1  one-cycle completion pulse.
- `rdata`  output  32  extended load data, valid while `done`=1; 0 for stores, errors and idle.
- `err`  output  1  pulses with `done` when the access timed out.
- `bus_req`  output  1  beat request.
- `bus_we`  output  1  1 = write beat.
- `bus_addr`  output  32  `addr + beat`, mod 2^32.
- `bus_wdata`  output  8  write byte.
- `bus_ack`  input  1  beat completes on any cycle where `bus_req & bus_ack` are both 1.
- `bus_rdata`  input  8  read byte, sampled on the completing cycle.

## Operation
- State machine with three states: IDLE, BEAT and DONE. Reset enters IDLE.
- **IDLE:**
  - If `mem_req` is high and an operation is present, latch `addr`, `wdata`, `load_unsigned`, size and direction, clear `beat` and the timeout counter, then go to BEAT.
  - Direction rule: a nonzero `MemWrite` selects a store and takes priority over `ResultSrc`. Otherwise a nonzero `ResultSrc` selects a load.
  - Both codes zero: no acceptance, no stall, no bus activity.
- Beat count: word 4, half 2, byte 1 (last beat = 3, 1, 0).
- Alignment is not checked; addresses wrap at 2^32.
- **BEAT:**
  - `bus_req`=1. `bus_we`, `bus_addr` and `bus_wdata` are driven from registers and held stable until acknowledged.
  - On handshake: for a load, store `bus_rdata` into byte lane `beat`. If this is the last beat, go to DONE. Otherwise increment `beat` and keep `bus_req` high, so back-to-back beats are allowed.
  - Without an ack, the timeout counter increments. When it reaches `TIMEOUT` (nonzero), go to DONE with the error flag set.
- **DONE:**
  - `done`=1 for one cycle and `err` = error flag.
  - `rdata` extension rules:
    - Byte: bits [31:8] filled with bit 7 if signed, else 0.
    - Half: bits [31:16] filled with bit 15 if signed, else 0.
    - Word: passed unchanged.
    - Store or error: `rdata`=0.
  - Always returns to IDLE.
- The core holds its request stable while `stall`=1. A new request seen after DONE is accepted in IDLE on the following cycle.
- Reset asserted mid-access: `bus_req` drops immediately, partial data is discarded and no `done` is produced.

## Timing
- Reset values: `stall` follows its inputs. `done`, `err`, `bus_req` and `bus_we` are 0; `rdata`, `bus_addr` and `bus_wdata` are 0.
- Acceptance at cycle T. Beats occupy cycles T+1 onward, one cycle each with zero-wait ack.
- N-beat access with zero-wait ack: `done` at T+N+1 and `stall` high for cycles T..T+N (word: 5 stall cycles).
- Each wait cycle on a beat adds one cycle.
- Timeout: `done`/`err` occur `TIMEOUT`+1 cycles after the stuck beat first asserts `bus_req`.

## Structure
- Shared package `riscv_mem_pkg` holds:
  - size codes `MEM_NONE` 00, `MEM_W` 01, `MEM_H` 10, `MEM_B` 11, shared with the controller;
  - the bridge state encoding.
- One combinational sub-module, `lsu_load_extend`, with inputs raw 32-bit data, size and unsigned flag, and output extended data.

## Test plan
- **Signed byte load:** `ResultSrc`=11, `addr`=0x100, `load_unsigned`=0, bus returns 0x80 with zero-wait ack. Required: one beat at 0x100, `done` at T+2, `rdata`=0xFFFFFF80. Repeat with `load_unsigned`=1; required `rdata`=0x00000080.
- **Word store:** `MemWrite`=01, `addr`=0x200, `wdata`=0xA1B2C3D4. Required: beats 0x200→D4, 0x201→C3, 0x202→B2, 0x203→A1 with `bus_we`=1, `done` at T+5, `rdata`=0.
- **Half load with wait states:** `ResultSrc`=10, 2-cycle ack delay per beat, bytes 0x34 then 0xF2. Required: `rdata`=0xFFFFF234 and `stall` high for 7 cycles, with bus signals stable during waits.
- **Timeout:** `TIMEOUT`=4, `bus_ack` never asserted. Required: `done`=`err`=1 at T+6, `rdata`=0, then IDLE.
- **Priority and no-op:** both codes nonzero gives a store. Both codes zero with `mem_req`=1 gives `stall`=0 and no `bus_req`. An address of 0xFFFFFFFE on a word store wraps, with beats at …FE, …FF, 0x0, 0x1.
- **Reset mid-access:** `reset` low during beat 2 of a word load. Required: `bus_req` drops asynchronously, no `done` follows, and the next request starts at beat 0.
